quad_gen: RTL and testbench

QUAD_GEN -- requirements
Module: quad_gen

---
 rtl/quad_gen_pkg.sv | 39 +++
 rtl/quad_gen_tick.sv | 29 ++
 rtl/quad_gen.sv | 122 ++++++++++++
 tb/tb_quad_gen.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_gen_pkg.sv
// Shared types and constants for the quadrature step generator.
// Phase codes are packed as {A, B}.
package quad_gen_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] PHASE_00 = 2'b00;
    localparam logic [1:0] PHASE_10 = 2'b10;
    localparam logic [1:0] PHASE_11 = 2'b11;
    localparam logic [1:0] PHASE_01 = 2'b01;

    localparam logic [31:0] RESET_POSITION = 32'h0000_8000;

    // Forward walks 00->10->11->01->00; reverse walks the same ring backwards.
    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
        logic [1:0] result;
        result = phase;
        if (dir) begin
            case (phase)
                PHASE_00: result = PHASE_10;
                PHASE_10: result = PHASE_11;
                PHASE_11: result = PHASE_01;
                default:  result = PHASE_00;
            endcase
        end else begin
            case (phase)
                PHASE_00: result = PHASE_01;
                PHASE_01: result = PHASE_11;
                PHASE_11: result = PHASE_10;
                default:  result = PHASE_00;
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/quad_gen_tick.sv
// Edge-period divider: counts enabled cycles and pulses tick on the last
// cycle of each period, restarting from zero.
module quad_gen_tick #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [PERIOD_W-1:0] period,
    input  logic                enable,
    input  logic                clear,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;

    // period is never zero here; the caller substitutes 1 when latching.
    assign tick = enable && (count == period - PERIOD_W'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/quad_gen.sv
// Quadrature step generator: emits cmd_steps A/B edges spaced cmd_period
// clocks apart and keeps a signed running tally of emitted edges.
module quad_gen
    import quad_gen_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int STEP_W   = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [STEP_W-1:0]   cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                quadA,
    output logic                quadB,
    output logic                busy,
    output logic                done,
    output logic signed [31:0]  position
);

    state_t              state;
    state_t              state_next;
    logic                dir;
    logic [PERIOD_W-1:0] period;
    logic [STEP_W-1:0]   remaining;
    logic [1:0]          phase;
    logic                accept;
    logic                running;
    logic                tick;
    logic                last_edge;

    assign accept    = cmd_valid && cmd_ready;
    assign running   = (state == RUN);
    assign last_edge = tick && (remaining == STEP_W'(1));

    // Abort gates the divider enable, so an abort coinciding with the
    // final divider count suppresses that edge.
    quad_gen_tick #(
        .PERIOD_W (PERIOD_W)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .period (period),
        .enable (running && !abort),
        .clear  (!running),
        .tick   (tick)
    );

    // NOTE: state elements use non-blocking assignment so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment at the top of each always_comb keeps
    // every path assigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (cmd_steps != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort || last_edge) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE) && resetn;
        busy      = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dir       <= 1'b1;
            period    <= PERIOD_W'(1);
            remaining <= '0;
            phase     <= PHASE_00;
            position  <= RESET_POSITION;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                dir       <= cmd_dir;
                period    <= (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
                remaining <= cmd_steps;
                if (cmd_steps == '0) begin
                    done <= 1'b1;
                end
            end
            if (running) begin
                if (abort) begin
                    done <= 1'b1;
                end else if (tick) begin
                    phase     <= next_phase(phase, dir);
                    position  <= dir ? position + 32'sd1 : position - 32'sd1;
                    remaining <= remaining - STEP_W'(1);
                    if (last_edge) begin
                        done <= 1'b1;
                    end
                end
            end
        end
    end

    assign quadA = phase[1];
    assign quadB = phase[0];

endmodule

// File: tb/tb_quad_gen.sv
// Scoreboard bench for quad_gen: every command pushes its expected edges and
// done pulse; a negedge monitor pops and compares them as the DUT produces them.
module tb_quad_gen;

    localparam int PW = 16;
    localparam int SW = 16;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_dir = 1'b0;
    logic [SW-1:0]       cmd_steps = '0;
    logic [PW-1:0]       cmd_period = '0;
    logic                abort = 1'b0;
    logic                cmd_ready;
    logic                quadA;
    logic                quadB;
    logic                busy;
    logic                done;
    logic signed [31:0]  position;

    always #5 clk = ~clk;

    quad_gen #(
        .PERIOD_W (PW),
        .STEP_W   (SW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .quadA      (quadA),
        .quadB      (quadB),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    typedef struct {
        logic [1:0]  ab;
        logic [31:0] pos;
        int          cyc;
    } edge_exp_t;

    edge_exp_t   edge_q[$];
    int          done_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          m_idx = 0;
    logic [31:0] m_pos = 32'h0000_8000;
    bit          mon_en = 1'b0;
    logic [1:0]  prev_ab = 2'b00;
    int          edges_seen = 0;
    int          dec_cnt = 0;
    logic [1:0]  dec_prev = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [1:0] ab_of(input int idx);
        case (idx % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int idx_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Independent quadrature decoder used for the loopback check.
    always @(posedge clk) begin
        if (resetn) begin
            if (idx_of({quadA, quadB}) == (idx_of(dec_prev) + 1) % 4) dec_cnt <= dec_cnt + 1;
            else if (idx_of({quadA, quadB}) == (idx_of(dec_prev) + 3) % 4) dec_cnt <= dec_cnt - 1;
        end
        dec_prev <= {quadA, quadB};
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if ({quadA, quadB} != prev_ab) begin
                edge_exp_t e;
                edges_seen++;
                if (edge_q.size() == 0) begin
                    check("spurious_edge", 32'(1), 32'(0));
                end else begin
                    e = edge_q.pop_front();
                    check("edge_ab", 32'({quadA, quadB}), 32'(e.ab));
                    check("edge_pos", position, e.pos);
                    check("edge_cyc", 32'(cyc), 32'(e.cyc));
                end
                prev_ab = {quadA, quadB};
            end
            if (done) begin
                if (done_q.size() == 0) check("spurious_done", 32'(1), 32'(0));
                else check("done_cyc", 32'(cyc), 32'(done_q.pop_front()));
            end
        end
    end

    // Drives one command and pushes n_edges expected edges plus a done pulse
    // done_delay cycles after acceptance (none when done_delay < 0).
    task automatic issue(input logic dir, input int steps, input int period,
                         input int n_edges, input int done_delay, output int acc);
        int peff;
        edge_exp_t e;
        peff = (period == 0) ? 1 : period;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'(1));
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = SW'(steps);
        cmd_period = PW'(period);
        acc = cyc + 1;
        for (int i = 1; i <= n_edges; i++) begin
            m_idx = (m_idx + (dir ? 1 : 3)) % 4;
            m_pos = dir ? m_pos + 32'd1 : m_pos - 32'd1;
            e.ab  = ab_of(m_idx);
            e.pos = m_pos;
            e.cyc = acc + i * peff;
            edge_q.push_back(e);
        end
        if (done_delay >= 0) done_q.push_back(acc + done_delay);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while ((busy || edge_q.size() != 0 || done_q.size() != 0) && k < budget);
        check("idle_reached", 32'({busy, edge_q.size() != 0, done_q.size() != 0}), 32'(0));
    endtask

    task automatic wait_edges(input int target, input int budget);
        int k;
        k = 0;
        while (edges_seen < target && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("edges_reached", 32'(edges_seen), 32'(target));
    endtask

    initial begin
        int acc;
        int base;

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a", 32'(quadA), 32'(0));
        check("rst_b", 32'(quadB), 32'(0));
        check("rst_pos", position, 32'h0000_8000);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ready", 32'(cmd_ready), 32'(0));
        resetn = 1'b1;
        #1 check("ready_after_rst", 32'(cmd_ready), 32'(1));
        prev_ab = 2'b00;
        mon_en  = 1'b1;

        // Forward move: 8 edges every 4 clocks.
        issue(1'b1, 8, 4, 8, 32, acc);
        wait_idle(100);
        check("fwd_pos", position, 32'h0000_8008);
        check("fwd_ab", 32'({quadA, quadB}), 32'(2'b00));

        // Reverse move on consecutive clocks from phase 00.
        issue(1'b0, 3, 1, 3, 3, acc);
        wait_idle(20);
        check("rev_pos", position, 32'h0000_8005);
        check("rev_ab", 32'({quadA, quadB}), 32'(2'b10));

        // Loopback through the bench decoder.
        issue(1'b1, 100, 5, 100, 500, acc);
        wait_idle(700);
        @(negedge clk);
        check("loop_pos", position, m_pos);
        check("loop_dec", 32'(dec_cnt), m_pos - 32'h0000_8000);

        // Abort after exactly 10 edges of a 50-step move.
        base = edges_seen;
        issue(1'b1, 50, 2, 10, 21, acc);
        wait_edges(base + 10, 100);
        abort = 1'b1;
        @(negedge clk);
        #2 abort = 1'b0;
        wait_idle(20);
        repeat (4) @(negedge clk);
        check("abort_edges", 32'(edges_seen - base), 32'(10));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_phase", 32'({quadA, quadB}), 32'(ab_of(m_idx)));
        check("abort_pos", position, m_pos);

        // Abort in the same cycle an edge would fire: no edge, done still pulses.
        issue(1'b1, 5, 3, 0, 3, acc);
        repeat (3) @(negedge clk);
        #2 abort = 1'b1;
        @(negedge clk);
        #2 abort = 1'b0;
        wait_idle(20);
        check("abort_tick_pos", position, m_pos);

        // Abort in IDLE does nothing.
        @(negedge clk);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        #2 check("idle_abort_busy", 32'(busy), 32'(0));
        abort = 1'b0;

        // Zero-length move: done the next cycle, no edges.
        issue(1'b1, 0, 4, 0, 0, acc);
        wait_idle(10);
        check("zero_busy", 32'(busy), 32'(0));
        check("zero_pos", position, m_pos);

        // Period 0 behaves as period 1.
        issue(1'b1, 4, 0, 4, 4, acc);
        wait_idle(20);
        check("p0_pos", position, m_pos);

        // Command offered while busy must not be accepted.
        issue(1'b0, 6, 3, 6, 18, acc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid  = 1'b1;
            cmd_dir    = 1'b1;
            cmd_steps  = SW'(2);
            cmd_period = PW'(1);
            #1 check("ready_busy", 32'(cmd_ready), 32'(0));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(40);
        check("busy_cmd_pos", position, m_pos);

        // Reset in the middle of a move.
        base = edges_seen;
        issue(1'b1, 20, 2, 3, -1, acc);
        wait_edges(base + 3, 50);
        mon_en = 1'b0;
        resetn = 1'b0;
        edge_q.delete();
        done_q.delete();
        m_idx = 0;
        m_pos = 32'h0000_8000;
        @(negedge clk);
        check("mid_rst_ab", 32'({quadA, quadB}), 32'(0));
        check("mid_rst_pos", position, 32'h0000_8000);
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        resetn = 1'b1;
        #1 check("mid_rst_ready", 32'(cmd_ready), 32'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_done", 32'(done), 32'(0));
        end
        prev_ab = 2'b00;
        mon_en  = 1'b1;

        // Fresh move after reset starts from phase 00.
        issue(1'b1, 2, 1, 2, 2, acc);
        wait_idle(20);
        check("post_rst_pos", position, 32'h0000_8002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
